// File: rtl/mux_rr_scheduler_pkg.sv
// Purpose: shared constants and FSM state type for the round-robin mux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_rr_scheduler_pkg;

  localparam int NREQ       = 16;
  localparam int SEL_W      = 4;
  localparam int DW_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick16.sv
// Purpose: combinational round-robin search over 16 requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: req[15:0] requests, ptr[3:0] last accepted index,
//        any = some request set, idx[3:0] = first set bit scanning up from ptr+1 (mod 16).
module rr_pick16
  import mux_rr_scheduler_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Offsets 1..16; offset 16 truncates back to ptr itself, so the last
  // accepted index has the lowest priority.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Purpose: round-robin scheduler that captures one of 16 requester words and offers it downstream.
// Latency: request in IDLE -> out_valid on the next cycle; back-to-back one transfer per cycle.
// Backpressure: out_ready low holds sel/out_data stable; the captured word is never withdrawn.
// Ports: clk, rst_n (async active-low); req[15:0], din[16*DW-1:0] requester side;
//        out_valid/out_ready/out_data consumer side; sel = granted index;
//        gnt = one-hot acknowledge on the accepting cycle; xfer_cnt = wrapping transfer count.
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [SEL_W-1:0]     sel,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          xfer_cnt
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             xfer;
  logic [NREQ-1:0]  sel_onehot;
  logic [NREQ-1:0]  pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  assign xfer       = (state_q == BUSY) && out_ready;
  assign sel_onehot = NREQ'(1) << sel_q;

  // On an accepting cycle the just-served requester still shows req high,
  // so it is masked out and the search starts after it.
  assign pick_req = xfer ? (req & ~sel_onehot) : req;
  assign pick_ptr = xfer ? sel_q : ptr_q;

  rr_pick16 u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (xfer) begin
      ptr_d = sel_q;
      cnt_d = cnt_q + 16'd1;
    end

    // Arbitrate only when nothing is held: idle, or the held word leaves now.
    if ((state_q == IDLE) || xfer) begin
      if (pick_any) begin
        state_d = BUSY;
        sel_d   = pick_idx;
        data_d  = din[pick_idx*DW +: DW];
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '1;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == BUSY);
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign gnt       = xfer ? sel_onehot : '0;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
`timescale 1ns/1ps
module tb_mux_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [63:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic [15:0] xfer_cnt;

  int n_cmp;
  int n_err;

  mux_rr_scheduler #(.DW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice i of DIN_A holds (i+10) mod 16: slice0=A, slice1=B, slice4=E, slice8=2, slice15=9.
  localparam logic [63:0] DIN_A  = 64'h9876543210FEDCBA;
  localparam logic [63:0] DIN_S5 = 64'h9876543210F5DCBA; // slice4 = 5
  localparam logic [63:0] DIN_SF = 64'h9876543210FFDCBA; // slice4 = F

  typedef struct {
    logic [15:0] req;
    logic [63:0] din;
    logic        rdy;
    logic        ev;
    logic [3:0]  esel;
    logic [3:0]  edata;
    logic [15:0] egnt;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    din       = DIN_A;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req       = '0;
    din       = DIN_A;
    out_ready = 1'b0;

    //            req       din     rdy   ev   sel   data  gnt       cnt
    tbl[0]  = '{16'h0000, DIN_A,  1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 16'd0};
    tbl[1]  = '{16'h0001, DIN_A,  1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 16'd0};
    tbl[2]  = '{16'h0000, DIN_A,  1'b1, 1'b1, 4'h0, 4'hA, 16'h0001, 16'd0};
    tbl[3]  = '{16'h8001, DIN_A,  1'b1, 1'b0, 4'h0, 4'hA, 16'h0000, 16'd1};
    tbl[4]  = '{16'h8001, DIN_A,  1'b1, 1'b1, 4'hF, 4'h9, 16'h8000, 16'd1};
    tbl[5]  = '{16'h0000, DIN_A,  1'b1, 1'b1, 4'h0, 4'hA, 16'h0001, 16'd2};
    tbl[6]  = '{16'h0010, DIN_S5, 1'b0, 1'b0, 4'h0, 4'hA, 16'h0000, 16'd3};
    tbl[7]  = '{16'h0010, DIN_S5, 1'b0, 1'b1, 4'h4, 4'h5, 16'h0000, 16'd3};
    tbl[8]  = '{16'h0100, DIN_SF, 1'b0, 1'b1, 4'h4, 4'h5, 16'h0000, 16'd3};
    tbl[9]  = '{16'h0100, DIN_SF, 1'b0, 1'b1, 4'h4, 4'h5, 16'h0000, 16'd3};
    tbl[10] = '{16'h0100, DIN_SF, 1'b0, 1'b1, 4'h4, 4'h5, 16'h0000, 16'd3};
    tbl[11] = '{16'h0100, DIN_SF, 1'b0, 1'b1, 4'h4, 4'h5, 16'h0000, 16'd3};
    tbl[12] = '{16'h0100, DIN_SF, 1'b1, 1'b1, 4'h4, 4'h5, 16'h0010, 16'd3};
    tbl[13] = '{16'h0000, DIN_SF, 1'b0, 1'b1, 4'h8, 4'h2, 16'h0000, 16'd4};
    tbl[14] = '{16'h0000, DIN_SF, 1'b1, 1'b1, 4'h8, 4'h2, 16'h0100, 16'd4};
    tbl[15] = '{16'h0000, DIN_A,  1'b1, 1'b0, 4'h8, 4'h2, 16'h0000, 16'd5};
    tbl[16] = '{16'h0001, DIN_A,  1'b1, 1'b0, 4'h8, 4'h2, 16'h0000, 16'd5};
    tbl[17] = '{16'h0001, DIN_A,  1'b1, 1'b1, 4'h0, 4'hA, 16'h0001, 16'd5};
    tbl[18] = '{16'h0001, DIN_A,  1'b1, 1'b0, 4'h0, 4'hA, 16'h0000, 16'd6};
    tbl[19] = '{16'h0000, DIN_A,  1'b1, 1'b1, 4'h0, 4'hA, 16'h0001, 16'd6};
    tbl[20] = '{16'h0000, DIN_A,  1'b0, 1'b0, 4'h0, 4'hA, 16'h0000, 16'd7};

    // Reset state
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_sel",   64'(sel),       64'd0);
    chk("rst_gnt",   64'(gnt),       64'd0);
    chk("rst_cnt",   64'(xfer_cnt),  64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Table: inputs applied in the low phase, outputs checked before the next rising edge.
    for (int i = 0; i < 21; i++) begin
      req       = tbl[i].req;
      din       = tbl[i].din;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("row%0d_sel", i),   64'(sel),       64'(tbl[i].esel));
      chk($sformatf("row%0d_data", i),  64'(out_data),  64'(tbl[i].edata));
      chk($sformatf("row%0d_gnt", i),   64'(gnt),       64'(tbl[i].egnt));
      chk($sformatf("row%0d_cnt", i),   64'(xfer_cnt),  64'(tbl[i].ecnt));
      @(negedge clk);
    end

    // Reset while a word is held and the consumer stalls.
    do_reset();
    req       = 16'h0010;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("s5_pre_valid", 64'(out_valid), 64'd1);
    chk("s5_pre_sel",   64'(sel),       64'd4);
    rst_n     = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(out_valid), 64'd0);
    chk("s5_rst_data",  64'(out_data),  64'd0);
    chk("s5_rst_sel",   64'(sel),       64'd0);
    chk("s5_rst_cnt",   64'(xfer_cnt),  64'd0);
    out_ready = 1'b1;
    #1;
    chk("s5_rst_gnt",   64'(gnt),       64'd0);
    @(negedge clk);
    req   = 16'h0006;
    rst_n = 1'b1;
    #1;
    chk("s5_rel_valid", 64'(out_valid), 64'd0);
    chk("s5_rel_gnt",   64'(gnt),       64'd0);
    @(negedge clk);
    #1;
    chk("s5_first_valid", 64'(out_valid), 64'd1);
    chk("s5_first_sel",   64'(sel),       64'd1);
    chk("s5_first_data",  64'(out_data),  64'hB);
    chk("s5_first_gnt",   64'(gnt),       64'h0002);

    // All requesters held: strict rotation, one transfer per cycle.
    do_reset();
    req       = 16'hFFFF;
    out_ready = 1'b1;
    #1;
    chk("s2_idle_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("s2_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("s2_sel%0d", k),   64'(sel),       64'(k % 16));
      chk($sformatf("s2_data%0d", k),  64'(out_data),  64'((k + 10) % 16));
      chk($sformatf("s2_gnt%0d", k),   64'(gnt),       64'(16'h1 << (k % 16)));
      chk($sformatf("s2_cnt%0d", k),   64'(xfer_cnt),  64'(k));
    end

    // Counter wrap after 65536 transfers.
    do_reset();
    req       = 16'hFFFF;
    out_ready = 1'b1;
    @(posedge clk);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    #1;
    chk("s6_cnt_max", 64'(xfer_cnt), 64'hFFFF);
    @(negedge clk);
    #1;
    chk("s6_cnt_wrap", 64'(xfer_cnt), 64'h0);
    chk("s6_valid",    64'(out_valid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
